// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: producer/consumer bundle for the write-back collector.
// Master is the core side (result sources, halt); slave is the collector.
interface regfile_writeback_if #(
  parameter int XLEN = 32
);
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            halt_req;
  logic            rd_we;
  logic [4:0]      rd_num;
  logic [XLEN-1:0] rd_data;
  logic [31:0]     pending_mask;
  logic            halted;

  modport master (
    output ld_valid, ld_rd, ld_data,
    output alu_valid, alu_rd, alu_data,
    output halt_req,
    input  ld_ready, alu_ready,
    input  rd_we, rd_num, rd_data,
    input  pending_mask, halted
  );

  modport slave (
    input  ld_valid, ld_rd, ld_data,
    input  alu_valid, alu_rd, alu_data,
    input  halt_req,
    output ld_ready, alu_ready,
    output rd_we, rd_num, rd_data,
    output pending_mask, halted
  );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order FIFO merging ALU and load results onto the
// single register-file write port; raises halted once every write commits.
module regfile_writeback #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  regfile_writeback_if.slave wb
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] LD_MAX  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ALU_MAX = CW'(DEPTH - 2);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_e;

  state_e          state_q, state_d;
  logic            halted_q, halted_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]      rd_mem_q  [DEPTH];
  logic [4:0]      rd_mem_d  [DEPTH];
  logic [XLEN-1:0] dat_mem_q [DEPTH];
  logic [XLEN-1:0] dat_mem_d [DEPTH];

  logic        ld_ready;
  logic        alu_ready;
  logic        ld_push;
  logic        alu_push;
  logic        pop;
  logic [31:0] pend;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    ptr_inc = (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  // Readiness depends only on registered state; one slot kept for loads.
  assign ld_ready  = (state_q == S_RUN) && (count_q <= LD_MAX);
  assign alu_ready = (state_q == S_RUN) && (count_q <= ALU_MAX);

  // x0 writes complete the handshake but never occupy a slot.
  assign ld_push  = wb.ld_valid  && ld_ready  && (wb.ld_rd  != 5'd0);
  assign alu_push = wb.alu_valid && alu_ready && (wb.alu_rd != 5'd0);
  assign pop      = (count_q != '0);

  assign wb.ld_ready  = ld_ready;
  assign wb.alu_ready = alu_ready;
  assign wb.rd_we     = pop;
  assign wb.rd_num    = pop ? rd_mem_q[rd_ptr_q]  : 5'd0;
  assign wb.rd_data   = pop ? dat_mem_q[rd_ptr_q] : '0;
  assign wb.halted    = halted_q;

  // FIFO next state: pop head, then append load (older) before ALU.
  always_comb begin
    rd_mem_d  = rd_mem_q;
    dat_mem_d = dat_mem_q;
    vld_d     = vld_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    if (ld_push) begin
      rd_mem_d[wr_ptr_d]  = wb.ld_rd;
      dat_mem_d[wr_ptr_d] = wb.ld_data;
      vld_d[wr_ptr_d]     = 1'b1;
      wr_ptr_d            = ptr_inc(wr_ptr_d);
    end
    if (alu_push) begin
      rd_mem_d[wr_ptr_d]  = wb.alu_rd;
      dat_mem_d[wr_ptr_d] = wb.alu_data;
      vld_d[wr_ptr_d]     = 1'b1;
      wr_ptr_d            = ptr_inc(wr_ptr_d);
    end
  end

  // Occupancy: up to two pushes and one pop per edge.
  always_comb begin
    count_d = count_q
            + CW'(ld_push)
            + CW'(alu_push)
            - CW'(pop);
  end

  // Halt sequencing: stop accepting, drain, then report halted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:    if (wb.halt_req) state_d = S_DRAIN;
      S_DRAIN:  if (count_q == '0) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
    halted_d = (state_d == S_HALTED);
  end

  // Destinations still waiting to commit; x0 never queued.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pend[rd_mem_q[i]] = 1'b1;
    end
  end

  assign wb.pending_mask = {pend[31:1], 1'b0};

  // State registers with synchronous reset that discards queued writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      halted_q <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]  <= '0;
        dat_mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      vld_q     <= vld_d;
      rd_mem_q  <= rd_mem_d;
      dat_mem_q <= dat_mem_d;
    end
  end
endmodule
